// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage connection to the multiply/divide HI/LO sequencer.
// start is the issue strobe (valid) for one cycle; busy is the stall (not-ready) seen in that same cycle.
interface muldiv_hilo_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo, state
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo, state
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes,
// a combinational stall and exception flush.
module muldiv_hilo_ctrl #(
    parameter int MUL_LAT = 2
) (
    input logic               clk,
    input logic               rst,
    muldiv_hilo_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
    localparam logic [5:0] DIV_CNT = 6'd32;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        is_signed;
    logic        is_mul;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [63:0] acc;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        issue;
    logic        is_mul_op;
    logic        is_div_op;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    logic [63:0] product;
    logic [33:0] trial;
    logic [63:0] step_acc;
    logic        commit_en;
    logic [31:0] commit_hi;
    logic [31:0] commit_lo;

    always_comb begin
        is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        issue     = (state == S_IDLE) && bus.start && !bus.flush;
        abs_a     = (bus.op == OP_DIV && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
        abs_b     = (bus.op == OP_DIV && bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;
    end

    // Sign- or zero-extending to 64 bits lets one multiplier serve both MULT and MULTU.
    always_comb begin
        ext_a   = {{32{is_signed & opa[31]}}, opa};
        ext_b   = {{32{is_signed & opb[31]}}, opb};
        product = 64'(ext_a * ext_b);
    end

    // acc holds {partial remainder, dividend shifting out / quotient shifting in}.
    always_comb begin
        trial = {1'b0, acc[63:31]} - {2'b00, opb};
        if (trial[33]) begin
            step_acc = {acc[62:0], 1'b0};
        end else begin
            step_acc = {trial[31:0], acc[30:0], 1'b1};
        end
    end

    always_comb begin
        commit_en = (state == S_DONE) && !bus.flush && (is_mul || !div_zero);
        if (is_mul) begin
            commit_hi = acc[63:32];
            commit_lo = acc[31:0];
        end else begin
            commit_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
            commit_lo = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 6'd0;
            opa       <= 32'd0;
            opb       <= 32'd0;
            is_signed <= 1'b0;
            is_mul    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            acc       <= 64'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue && is_mul_op) begin
                        opa       <= bus.src_a;
                        opb       <= bus.src_b;
                        is_signed <= (bus.op == OP_MULT);
                        is_mul    <= 1'b1;
                        cnt       <= MUL_CNT;
                        state     <= S_MUL;
                    end else if (issue && is_div_op) begin
                        opb       <= abs_b;
                        acc       <= {32'd0, abs_a};
                        neg_q     <= (bus.op == OP_DIV) && (bus.src_a[31] ^ bus.src_b[31]);
                        neg_r     <= (bus.op == OP_DIV) && bus.src_a[31];
                        div_zero  <= (bus.src_b == 32'd0);
                        is_mul    <= 1'b0;
                        cnt       <= DIV_CNT;
                        state     <= S_DIV;
                    end else if (issue && bus.op == OP_MTHI) begin
                        hi_r <= bus.src_a;
                    end else if (issue && bus.op == OP_MTLO) begin
                        lo_r <= bus.src_a;
                    end
                end
                S_MUL: begin
                    if (bus.flush) begin
                        cnt   <= 6'd0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1) begin
                            acc   <= product;
                            state <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        cnt   <= 6'd0;
                        state <= S_IDLE;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (commit_en) begin
                        hi_r <= commit_hi;
                        lo_r <= commit_lo;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = (issue && (is_mul_op || is_div_op)) || (state == S_MUL) || (state == S_DIV);
    assign bus.done  = (state == S_DONE) && !bus.flush;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.state = state;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed plus randomized bench for muldiv_hilo_ctrl against an arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;
  localparam int MUL_LAT = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic [31:0] specials [4];

  muldiv_hilo_ctrl_if bus ();

  muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: HI/LO update from the instruction's arithmetic meaning
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint prod;
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin
        prod = longint'(sa) * longint'(sb);
        hi_m = prod[63:32];
        lo_m = prod[31:0];
      end
      3'd1: begin
        prod = longint'({32'd0, a}) * longint'({32'd0, b});
        hi_m = prod[63:32];
        lo_m = prod[31:0];
      end
      3'd2: begin
        if (b != 0) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            lo_m = 32'h80000000;
            hi_m = 32'h0;
          end else begin
            lo_m = sa / sb;
            hi_m = sa % sb;
          end
        end
      end
      3'd3: begin
        if (b != 0) begin
          lo_m = a / b;
          hi_m = a % b;
        end
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  // driver: called just after a falling edge; issues in this cycle and runs to completion
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    bit muldiv;
    int done_cyc;
    muldiv   = (op <= 3'd3);
    done_cyc = (op <= 3'd1) ? MUL_LAT + 1 : 33;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    #1;
    check("issue_busy", 32'(bus.busy), 32'(muldiv));
    check("issue_done", 32'(bus.done), 32'd0);
    if (muldiv) begin
      for (int k = 1; k <= done_cyc; k++) begin
        @(negedge clk);
        if (noise) begin
          bus.start = 1'b1;
          bus.op    = 3'b100;
          bus.src_a = $urandom;
        end else begin
          bus.start = 1'b0;
        end
        #1;
        check("run_busy", 32'(bus.busy), 32'(k < done_cyc));
        check("run_done", 32'(bus.done), 32'(k == done_cyc));
      end
    end
    model(op, a, b);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("after_done", 32'(bus.done), 32'd0);
    check("hi", bus.hi, hi_m);
    check("lo", bus.lo, lo_m);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    hi_m  = 32'd0;
    lo_m  = 32'd0;
    specials[0] = 32'h00000000;
    specials[1] = 32'h80000000;
    specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h00000001;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed scenarios, issued back to back
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, 1'b0);
    run_op(3'd4, 32'h11111111, 32'd0, 1'b0);
    run_op(3'd5, 32'h22222222, 32'd0, 1'b0);
    run_op(3'd3, 32'd7, 32'd0, 1'b0);
    run_op(3'd2, 32'hFFFFFFF9, 32'd0, 1'b0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, 1'b0);
    run_op(3'd6, 32'hDEADBEEF, 32'd1, 1'b0);
    run_op(3'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1);

    // flush mid-divide at cycle 10
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = (k == 10);
    end
    #1;
    check("flush_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_hi", bus.hi, hi_m);
    check("flush_lo", bus.lo, lo_m);
    run_op(3'd0, 32'd5, 32'd6, 1'b0);

    // flush landing on the DONE cycle suppresses the commit
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.src_a = 32'd7;
    bus.src_b = 32'd9;
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = (k == MUL_LAT + 1);
    end
    #1;
    check("flush_done_pulse", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flushdone_hi", bus.hi, hi_m);
    check("flushdone_lo", bus.lo, lo_m);

    // flush in the issue cycle wins over start
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.flush = 1'b1;
    #1;
    check("issue_flush_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("issue_flush_idle", 32'(bus.busy), 32'd0);
    run_op(3'd4, 32'hCAFEF00D, 32'd0, 1'b0);

    // asynchronous reset between edges mid-divide
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.src_a = 32'd50;
    bus.src_b = 32'd5;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check("arst_hi", bus.hi, hi_m);
    check("arst_lo", bus.lo, lo_m);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'd3, 32'd100, 32'd7, 1'b0);

    // randomized stimulus
    for (int n = 0; n < 30; n++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 20));
      run_op(rop, ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
